bcd_stopwatch: RTL and testbench
================================

BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 SHALL have parameter PRESCALE, default 10000: clk cycles per 10 ms tick; legal range >= 2.
REQ-002 SHALL have parameter MIN_DIGITS, default 2: number of BCD minute digits; legal range 1..3.
REQ-003 SHALL have parameter WRAP, default 1: 1 = roll over to zero at maximum count; 0 = saturate at maximum.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port ena  input  1  global enable; low freezes all state.
REQ-007 SHALL have port start_stop  input  1  one-cycle pulse, debounced upstream.
REQ-008 SHALL have port lap  input  1  one-cycle pulse, debounced upstream.
REQ-009 SHALL have port clear  input  1  one-cycle pulse, debounced upstream.
REQ-010 SHALL have port disp_bcd  output  4*(4+MIN_DIGITS)  displayed digits, LSB nibble first: cs units, cs tens, s units, s tens, minutes units upward.
REQ-011 SHALL have port running  output  1  high in RUNNING or LAP.
REQ-012 SHALL have port lap_active  output  1  high in LAP.
REQ-013 SHALL have port overflow  output  1  sticky; set on reaching maximum count.
REQ-014 SHALL have port disp_update  output  1  one-cycle pulse in the cycle after disp_bcd changes.

Function
REQ-015 SHALL implement FSM states IDLE, RUNNING, STOPPED, LAP.
REQ-016 Input priority per cycle SHALL be clear > start_stop > lap; lower-priority pulses in the same cycle are discarded.
REQ-017 IDLE: start_stop -> RUNNING; lap and clear ignored.
REQ-018 RUNNING: start_stop -> STOPPED; lap -> LAP; clear ignored.
REQ-019 LAP: lap -> RUNNING; start_stop -> STOPPED; clear ignored; counting continues.
REQ-020 STOPPED: start_stop -> RUNNING; clear -> IDLE with count, prescaler and overflow zeroed; lap ignored.
REQ-021 Prescaler SHALL count 0..PRESCALE-1 only in RUNNING/LAP; it SHALL hold in STOPPED, so resume keeps sub-tick phase.
REQ-022 Tick SHALL fire on the cycle the prescaler equals PRESCALE-1; the count SHALL increment by 1 cs on that same edge.
REQ-023 Digit moduli SHALL be 10,10,10,6, then 10 for each minute digit; carries ripple within one cycle.
REQ-024 Maximum count SHALL be all minute digits 9, 59.99 s.
REQ-025 Tick at maximum with WRAP=1: count -> all zero, overflow set.
REQ-026 Tick at maximum with WRAP=0: count held, overflow set, state unchanged.
REQ-027 disp_bcd SHALL show the live count in all states except LAP.
REQ-028 On entry to LAP, the count present before that edge SHALL be latched; disp_bcd SHALL show the latch until LAP exits.
REQ-029 A start_stop from LAP SHALL show the live (stopped) count from the next cycle.
REQ-030 With ena low, FSM, prescaler, count, latch and outputs SHALL hold, and input pulses SHALL be ignored.
REQ-031 disp_bcd, running, lap_active and overflow SHALL be registered outputs.

Reset
REQ-032 While rst_n is low, the block SHALL immediately enter IDLE, independent of clk.
REQ-033 While rst_n is low, all of the following SHALL be 0: count, prescaler, lap latch, disp_bcd, running, lap_active, overflow, disp_update.
REQ-034 Reset asserted mid-count SHALL discard all state, with no partial tick.

Structure
REQ-035 Shared package stopwatch_pkg SHALL hold the FSM state enum, the digit width constant (4), and the digit moduli constants.
REQ-036 Per-digit counter SHALL be sub-module bcd_digit: parameter MODULUS; ports inc and carry_in; outputs digit, carry_out, at_max.
REQ-037 Illegal parameter values SHALL fail elaboration.

Verification (PRESCALE=4, MIN_DIGITS=2 unless stated)
REQ-038 Reset, start_stop, 40 cycles -> count 00:00.10; running=1; disp_update pulses 10 times.
REQ-039 Run to 1000 ticks, start_stop, idle 20 cycles, start_stop, 2 cycles -> count holds 00:10.00 while stopped; prescaler phase preserved; first tick after resume arrives at the preserved phase.
REQ-040 Run to 00:05.00, lap, run 200 more ticks -> disp_bcd stays 00:05.00; then lap -> disp_bcd shows 00:07.00.
REQ-041 Preload/run to 99:59.99: WRAP=1 next tick -> 00:00.00 with overflow=1; WRAP=0 next tick -> holds 99:59.99 with overflow=1; clear after stop -> IDLE, overflow=0.
REQ-042 In STOPPED, clear+start_stop in the same cycle -> IDLE with zero count; in RUNNING, start_stop+lap in the same cycle -> STOPPED, lap_active=0.
REQ-043 With ena=0 for 50 cycles mid-run, including a start_stop pulse -> no count change and no state change; rst_n pulse mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM states, digit width
// and the per-position digit moduli (cs units, cs tens, s units, s tens, minutes).
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STOPPED = 2'd2,
        ST_LAP     = 2'd3
    } sw_state_t;

    localparam int DIGIT_W      = 4;
    localparam int MOD_CS_UNITS = 10;
    localparam int MOD_CS_TENS  = 10;
    localparam int MOD_S_UNITS  = 10;
    localparam int MOD_S_TENS   = 6;
    localparam int MOD_MIN      = 10;

    function automatic int digit_modulus(input int idx);
        case (idx)
            0:       return MOD_CS_UNITS;
            1:       return MOD_CS_TENS;
            2:       return MOD_S_UNITS;
            3:       return MOD_S_TENS;
            default: return MOD_MIN;
        endcase
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch count. Steps when inc and carry_in are both
// high and wraps to zero past MODULUS-1; digit_nxt exposes the value after this edge.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MODULUS = 10
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    input  logic               carry_in,
    output logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] digit_nxt,
    output logic               carry_out,
    output logic               at_max
);

    if (MODULUS < 2 || MODULUS > 10) begin : g_bad_modulus
        $error("bcd_digit: MODULUS must be in 2..10");
    end

    localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(MODULUS - 1);

    logic [DIGIT_W-1:0] r_digit;

    assign at_max    = (r_digit == TOP);
    assign carry_out = carry_in & at_max;
    assign digit     = r_digit;

    always_comb begin
        digit_nxt = r_digit;
        if (clr)
            digit_nxt = '0;
        else if (inc && carry_in)
            digit_nxt = at_max ? '0 : r_digit + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_digit <= '0;
        else
            r_digit <= digit_nxt;
    end

endmodule

// File: rtl/bcd_stopwatch.sv
// Centisecond BCD stopwatch with lap-hold display, clear from STOPPED,
// and a sticky overflow flag; counting advances once per PRESCALE clocks.
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int PRESCALE   = 10000,
    parameter int MIN_DIGITS = 2,
    parameter int WRAP       = 1
)(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                ena,
    input  logic                                start_stop,
    input  logic                                lap,
    input  logic                                clear,
    output logic [DIGIT_W*(4+MIN_DIGITS)-1:0]   disp_bcd,
    output logic                                running,
    output logic                                lap_active,
    output logic                                overflow,
    output logic                                disp_update
);

    if (PRESCALE < 2) begin : g_bad_prescale
        $error("bcd_stopwatch: PRESCALE must be >= 2");
    end
    if (MIN_DIGITS < 1 || MIN_DIGITS > 3) begin : g_bad_min_digits
        $error("bcd_stopwatch: MIN_DIGITS must be in 1..3");
    end
    if (WRAP != 0 && WRAP != 1) begin : g_bad_wrap
        $error("bcd_stopwatch: WRAP must be 0 or 1");
    end

    localparam int NDIG = 4 + MIN_DIGITS;
    localparam int CW   = DIGIT_W * NDIG;
    localparam int PW   = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_TOP = PW'(PRESCALE - 1);

    sw_state_t        r_state;
    logic [PW-1:0]    r_presc;
    logic [CW-1:0]    r_latch;
    logic [CW-1:0]    r_disp;
    logic             r_running;
    logic             r_lap_active;
    logic             r_ovf;
    logic             r_upd;

    logic [CW-1:0]    w_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CW-1:0]    w_disp_nxt;
    logic [NDIG:0]    w_carry;
    logic [NDIG-1:0]  w_at_max;
    logic             w_ss_ev;
    logic             w_lap_ev;
    logic             w_clr_ev;
    logic             w_lap_enter;
    logic             w_lap_next;
    logic             w_counting;
    logic             w_tick;
    logic             w_inc;
    logic             w_all_max;

    // clear outranks start_stop outranks lap, even when the winner is ignored
    assign w_ss_ev     = ena && !clear && start_stop;
    assign w_lap_ev    = ena && !clear && !start_stop && lap;
    assign w_clr_ev    = ena && clear && (r_state == ST_STOPPED);
    assign w_lap_enter = (r_state == ST_RUNNING) && w_lap_ev;
    assign w_lap_next  = w_lap_enter || ((r_state == ST_LAP) && !w_ss_ev && !w_lap_ev);

    assign w_counting = ena && ((r_state == ST_RUNNING) || (r_state == ST_LAP));
    assign w_tick     = w_counting && (r_presc == PRE_TOP);
    assign w_all_max  = &w_at_max;
    assign w_inc      = w_tick && ((WRAP == 1) || !w_all_max);

    assign w_carry[0] = 1'b1;
    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        bcd_digit #(.MODULUS(digit_modulus(i))) u_dig (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (w_clr_ev),
            .inc       (w_inc),
            .carry_in  (w_carry[i]),
            .digit     (w_cnt[i*DIGIT_W +: DIGIT_W]),
            .digit_nxt (w_cnt_nxt[i*DIGIT_W +: DIGIT_W]),
            .carry_out (w_carry[i+1]),
            .at_max    (w_at_max[i])
        );
    end

    // Entering LAP shows the pre-edge count; staying in LAP keeps the latch.
    assign w_disp_nxt = w_lap_next ? ((r_state == ST_LAP) ? r_latch : w_cnt) : w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
        end else if (ena) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ss_ev) begin
                        r_state   <= ST_RUNNING;
                        r_running <= 1'b1;
                    end
                end
                ST_RUNNING: begin
                    if (w_ss_ev) begin
                        r_state   <= ST_STOPPED;
                        r_running <= 1'b0;
                    end else if (w_lap_ev) begin
                        r_state      <= ST_LAP;
                        r_lap_active <= 1'b1;
                    end
                end
                ST_LAP: begin
                    if (w_ss_ev) begin
                        r_state      <= ST_STOPPED;
                        r_running    <= 1'b0;
                        r_lap_active <= 1'b0;
                    end else if (w_lap_ev) begin
                        r_state      <= ST_RUNNING;
                        r_lap_active <= 1'b0;
                    end
                end
                ST_STOPPED: begin
                    if (w_clr_ev) begin
                        r_state <= ST_IDLE;
                    end else if (w_ss_ev) begin
                        r_state   <= ST_RUNNING;
                        r_running <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_running    <= 1'b0;
                    r_lap_active <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_latch <= '0;
            r_disp  <= '0;
            r_ovf   <= 1'b0;
            r_upd   <= 1'b0;
        end else if (ena) begin
            if (w_clr_ev)
                r_presc <= '0;
            else if (w_counting)
                r_presc <= w_tick ? '0 : r_presc + 1'b1;

            // carry out of the top digit means this tick starts at the maximum count
            if (w_clr_ev)
                r_ovf <= 1'b0;
            else if (w_tick && w_carry[NDIG])
                r_ovf <= 1'b1;

            if (w_lap_enter)
                r_latch <= w_cnt;

            r_disp <= w_disp_nxt;
            r_upd  <= (w_disp_nxt != r_disp);
        end
    end

    assign disp_bcd    = r_disp;
    assign running     = r_running;
    assign lap_active  = r_lap_active;
    assign overflow    = r_ovf;
    assign disp_update = r_upd;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: a WRAP=1 and a WRAP=0 instance share stimulus and are
// compared every cycle against a centisecond-integer reference model.
module tb_bcd_stopwatch;

    localparam int P      = 4;
    localparam int MAXC   = 599999;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_STOP = 2;
    localparam int S_LAPS = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic ena   = 1'b1;
    logic ss    = 1'b0;
    logic lp    = 1'b0;
    logic cl    = 1'b0;

    logic [23:0] d_disp [2];
    logic        d_run  [2];
    logic        d_lap  [2];
    logic        d_ovf  [2];
    logic        d_upd  [2];

    int          m_st    [2];
    int          m_cnt   [2];
    int          m_presc [2];
    int          m_latch [2];
    logic        m_ovf   [2];
    logic        m_upd   [2];
    logic [23:0] m_disp  [2];

    int n_vec = 0;
    int n_err = 0;
    int upd_seen = 0;

    bcd_stopwatch #(.PRESCALE(P), .MIN_DIGITS(2), .WRAP(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start_stop(ss), .lap(lp), .clear(cl),
        .disp_bcd(d_disp[0]), .running(d_run[0]), .lap_active(d_lap[0]),
        .overflow(d_ovf[0]), .disp_update(d_upd[0])
    );

    bcd_stopwatch #(.PRESCALE(P), .MIN_DIGITS(2), .WRAP(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start_stop(ss), .lap(lp), .clear(cl),
        .disp_bcd(d_disp[1]), .running(d_run[1]), .lap_active(d_lap[1]),
        .overflow(d_ovf[1]), .disp_update(d_upd[1])
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int n);
        int cs, s, m;
        cs = n % 100;
        s  = (n / 100) % 60;
        m  = n / 6000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = S_IDLE; m_cnt[k] = 0; m_presc[k] = 0; m_latch[k] = 0;
            m_ovf[k] = 1'b0; m_upd[k] = 1'b0; m_disp[k] = '0;
        end
    endtask

    task automatic model_step();
        int ev, nxt;
        logic clr_now, counting;
        logic [23:0] dn;
        for (int k = 0; k < 2; k++) begin
            if (!ena) continue;
            ev = cl ? 3 : (ss ? 2 : (lp ? 1 : 0));
            nxt = m_st[k];
            clr_now = 1'b0;
            case (m_st[k])
                S_IDLE: if (ev == 2) nxt = S_RUN;
                S_RUN:  if (ev == 2) nxt = S_STOP; else if (ev == 1) nxt = S_LAPS;
                S_LAPS: if (ev == 2) nxt = S_STOP; else if (ev == 1) nxt = S_RUN;
                S_STOP: if (ev == 3) begin nxt = S_IDLE; clr_now = 1'b1; end
                        else if (ev == 2) nxt = S_RUN;
                default: nxt = S_IDLE;
            endcase
            counting = (m_st[k] == S_RUN) || (m_st[k] == S_LAPS);
            if (nxt == S_LAPS && m_st[k] != S_LAPS) m_latch[k] = m_cnt[k];
            if (counting) begin
                if (m_presc[k] == P - 1) begin
                    m_presc[k] = 0;
                    if (m_cnt[k] == MAXC) begin
                        m_ovf[k] = 1'b1;
                        m_cnt[k] = (k == 0) ? 0 : MAXC;
                    end else begin
                        m_cnt[k]++;
                    end
                end else begin
                    m_presc[k]++;
                end
            end
            if (clr_now) begin
                m_cnt[k] = 0; m_presc[k] = 0; m_ovf[k] = 1'b0;
            end
            dn = (nxt == S_LAPS) ? to_bcd(m_latch[k]) : to_bcd(m_cnt[k]);
            m_upd[k]  = (dn != m_disp[k]);
            m_disp[k] = dn;
            m_st[k]   = nxt;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("disp%0d", k), 32'(d_disp[k]), 32'(m_disp[k]));
            chk($sformatf("running%0d", k), 32'(d_run[k]), 32'((m_st[k] == S_RUN) || (m_st[k] == S_LAPS)));
            chk($sformatf("lap_active%0d", k), 32'(d_lap[k]), 32'(m_st[k] == S_LAPS));
            chk($sformatf("overflow%0d", k), 32'(d_ovf[k]), 32'(m_ovf[k]));
            chk($sformatf("disp_update%0d", k), 32'(d_upd[k]), 32'(m_upd[k]));
        end
    endtask

    task automatic step(input logic s, input logic l, input logic c);
        ss = s; lp = l; cl = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        upd_seen += int'(d_upd[0]);
        check_all();
        ss = 1'b0; lp = 1'b0; cl = 1'b0;
    endtask

    task automatic run_until(input int n);
        int guard;
        guard = 0;
        while (m_cnt[0] != n && guard < 20000) begin
            step(1'b0, 1'b0, 1'b0);
            guard++;
        end
        if (guard >= 20000) chk("run_until_timeout", 32'(d_disp[0]), 32'(to_bcd(n)));
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk("rst_disp_w1", 32'(d_disp[0]), 32'h0);
        chk("rst_running_w1", 32'(d_run[0]), 32'h0);
        chk("rst_overflow_w0", 32'(d_ovf[1]), 32'h0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
    endtask

    task preload();
        force u_w1.g_dig[0].u_dig.r_digit = 4'd8;
        force u_w1.g_dig[1].u_dig.r_digit = 4'd9;
        force u_w1.g_dig[2].u_dig.r_digit = 4'd9;
        force u_w1.g_dig[3].u_dig.r_digit = 4'd5;
        force u_w1.g_dig[4].u_dig.r_digit = 4'd9;
        force u_w1.g_dig[5].u_dig.r_digit = 4'd9;
        force u_w0.g_dig[0].u_dig.r_digit = 4'd8;
        force u_w0.g_dig[1].u_dig.r_digit = 4'd9;
        force u_w0.g_dig[2].u_dig.r_digit = 4'd9;
        force u_w0.g_dig[3].u_dig.r_digit = 4'd5;
        force u_w0.g_dig[4].u_dig.r_digit = 4'd9;
        force u_w0.g_dig[5].u_dig.r_digit = 4'd9;
        m_cnt[0] = MAXC - 1;
        m_cnt[1] = MAXC - 1;
        step(1'b0, 1'b0, 1'b0);
        release u_w1.g_dig[0].u_dig.r_digit;
        release u_w1.g_dig[1].u_dig.r_digit;
        release u_w1.g_dig[2].u_dig.r_digit;
        release u_w1.g_dig[3].u_dig.r_digit;
        release u_w1.g_dig[4].u_dig.r_digit;
        release u_w1.g_dig[5].u_dig.r_digit;
        release u_w0.g_dig[0].u_dig.r_digit;
        release u_w0.g_dig[1].u_dig.r_digit;
        release u_w0.g_dig[2].u_dig.r_digit;
        release u_w0.g_dig[3].u_dig.r_digit;
        release u_w0.g_dig[4].u_dig.r_digit;
        release u_w0.g_dig[5].u_dig.r_digit;
    endtask

    initial begin
        int g, r;
        #1 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // 10 ticks from a fresh start
        step(1'b1, 1'b0, 1'b0);
        upd_seen = 0;
        repeat (40) step(1'b0, 1'b0, 1'b0);
        chk("cs10_disp", 32'(d_disp[0]), 32'h000010);
        chk("cs10_running", 32'(d_run[0]), 32'h1);
        chk("cs10_updates", 32'(upd_seen), 32'd10);

        // stop at 10.00 s, hold, resume with preserved prescaler phase
        run_until(1000);
        step(1'b1, 1'b0, 1'b0);
        chk("stop_disp", 32'(d_disp[0]), 32'h001000);
        repeat (20) step(1'b0, 1'b0, 1'b0);
        chk("stopped_hold", 32'(d_disp[0]), 32'h001000);
        chk("stopped_running", 32'(d_run[0]), 32'h0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("resume_phase_hold", 32'(d_disp[0]), 32'h001000);
        step(1'b0, 1'b0, 1'b0);
        chk("resume_first_tick", 32'(d_disp[0]), 32'h001001);

        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("clear_disp", 32'(d_disp[0]), 32'h0);
        chk("clear_running", 32'(d_run[0]), 32'h0);

        // lap hold at 5.00 s while counting continues to 7.00 s
        step(1'b1, 1'b0, 1'b0);
        run_until(500);
        step(1'b0, 1'b1, 1'b0);
        chk("lap_enter_active", 32'(d_lap[0]), 32'h1);
        chk("lap_enter_disp", 32'(d_disp[0]), 32'h000500);
        run_until(700);
        chk("lap_hold_disp", 32'(d_disp[0]), 32'h000500);
        step(1'b0, 1'b1, 1'b0);
        chk("lap_exit_disp", 32'(d_disp[0]), 32'h000700);
        chk("lap_exit_active", 32'(d_lap[0]), 32'h0);

        // simultaneous pulses
        step(1'b1, 1'b1, 1'b0);
        chk("ss_lap_running", 32'(d_run[0]), 32'h0);
        chk("ss_lap_active", 32'(d_lap[0]), 32'h0);
        step(1'b1, 1'b0, 1'b1);
        chk("clr_ss_disp", 32'(d_disp[0]), 32'h0);
        chk("clr_ss_running", 32'(d_run[0]), 32'h0);

        // enable low freezes everything, then async reset mid-run
        step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        ena = 1'b0;
        for (int i = 0; i < 50; i++) step(i == 25, 1'b0, 1'b0);
        ena = 1'b1;
        chk("ena_low_running", 32'(d_run[0]), 32'h1);
        chk("ena_low_disp", 32'(d_disp[0]), 32'h000002);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        do_reset();

        // maximum count: wrap vs saturate
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        preload();
        step(1'b1, 1'b0, 1'b0);
        run_until(MAXC);
        chk("max_disp_w1", 32'(d_disp[0]), 32'h995999);
        chk("max_disp_w0", 32'(d_disp[1]), 32'h995999);
        g = 0;
        while (!m_ovf[0] && g < 16) begin
            step(1'b0, 1'b0, 1'b0);
            g++;
        end
        chk("wrap_disp_w1", 32'(d_disp[0]), 32'h0);
        chk("wrap_overflow_w1", 32'(d_ovf[0]), 32'h1);
        chk("sat_disp_w0", 32'(d_disp[1]), 32'h995999);
        chk("sat_overflow_w0", 32'(d_ovf[1]), 32'h1);
        chk("sat_running_w0", 32'(d_run[1]), 32'h1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("clr_ovf_w1", 32'(d_ovf[0]), 32'h0);
        chk("clr_ovf_w0", 32'(d_ovf[1]), 32'h0);
        chk("clr_disp_w0", 32'(d_disp[1]), 32'h0);

        // random single-pulse traffic with occasional enable drops
        repeat (400) begin
            ena = ($urandom_range(0, 9) != 0);
            r = $urandom_range(0, 15);
            step(r == 0, r == 1, r == 2);
        end
        ena = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
